life_board_loader: RTL and testbench

- Host-side writer for the 8x8 life array. Accepts a byte stream over a valid/ready handshake and assembles 16-bit tile words.
- Drives the array's tile write port (vali, vali_selector, write_enb) for tiles 0..3.
- Generates the generation-advance step pulse, either periodically or on demand.
- Step is suppressed while a board load is in progress, so the array never advances over a half-written board.

---
 rtl/life_board_loader.sv | 157 +++++++++++++++
 tb/tb_life_board_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_board_loader.sv
// -----------------------------------------------------------------------------
// life_board_loader
//
// Host-side writer for the 8x8 life array. A byte stream arriving over a
// valid/ready handshake is assembled into four 16-bit tile words (low byte
// first) and written through the array's tile port. The block also produces
// the generation-advance step pulse, periodically while run=1 or on demand
// via single_step. Stepping is held off while a board load is in progress.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   in_data[7:0]   stream byte
//   in_sof         byte is the first byte of a board frame
//   in_valid       byte valid
//   in_ready       loader can accept a byte (registered)
//   run            enables periodic stepping
//   single_step    one-cycle request for a single step
//   vali[15:0]     tile word to the array (registered, holds outside writes)
//   vali_selector  tile index 0..3 (registered, holds outside writes)
//   write_enb      tile write strobe (one-cycle pulse)
//   step           generation-advance pulse (one-cycle pulse)
//   busy           a frame load is in progress
//   load_done      one-cycle pulse together with the tile 3 write
//   frame_err      one-cycle pulse on a protocol violation
// -----------------------------------------------------------------------------
module life_board_loader #(
  parameter int unsigned STEP_PERIOD = 25000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        run,
  input  logic        single_step,
  output logic [15:0] vali,
  output logic [1:0]  vali_selector,
  output logic        write_enb,
  output logic        step,
  output logic        busy,
  output logic        load_done,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_PERIOD - 1);

  state_t           state;
  state_t           state_n;
  logic [1:0]       tile_idx;
  logic [7:0]       lo_byte;
  logic [CNT_W-1:0] step_cnt;
  logic             xfer;
  logic             step_req;

  assign xfer = in_valid && in_ready;
  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Next-state decode. An in_sof byte always (re)starts the frame as the tile 0
  // low byte, so any accepted in_sof byte leads to HI.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so every path assigns state_n; without it
    // the missing branches would infer a latch.
    state_n = state;
    case (state)
      IDLE:    if (xfer && in_sof) state_n = HI;
      LO:      if (xfer)           state_n = HI;
      HI:      if (xfer)           state_n = in_sof ? HI : WRITE;
      WRITE:   state_n = (tile_idx == 2'd3) ? IDLE : LO;
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Loader FSM with registered outputs. The tile word is registered on the
  // edge that accepts the high byte, so write_enb, vali and vali_selector are
  // all valid during the WRITE cycle itself.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      tile_idx      <= 2'd0;
      lo_byte       <= 8'h00;
      in_ready      <= 1'b0;
      vali          <= 16'h0000;
      vali_selector <= 2'd0;
      write_enb     <= 1'b0;
      load_done     <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout sequential logic, so every
      // right-hand side sees the pre-edge value regardless of statement order.
      state     <= state_n;
      // WRITE is the only state that cannot take a byte.
      in_ready  <= (state_n != WRITE);
      write_enb <= 1'b0;
      load_done <= 1'b0;
      frame_err <= 1'b0;

      if (xfer) begin
        if (in_sof) begin
          // Start or restart: already-written tiles stay as they are.
          lo_byte   <= in_data;
          tile_idx  <= 2'd0;
          frame_err <= (state != IDLE);
        end else begin
          case (state)
            IDLE:    frame_err <= 1'b1;
            LO:      lo_byte   <= in_data;
            HI: begin
              vali          <= {in_data, lo_byte};
              vali_selector <= tile_idx;
              write_enb     <= 1'b1;
              load_done     <= (tile_idx == 2'd3);
            end
            default: ;
          endcase
        end
      end

      // Two-bit index wraps 3 -> 0 on the final tile.
      if (state == WRITE) tile_idx <= tile_idx + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Step generator. Both request sources are only honoured in IDLE and share
  // one register, so a single_step coinciding with expiry yields one pulse.
  // Any busy cycle clears the counter, so after a load the full period runs
  // again before the next automatic step.
  // ---------------------------------------------------------------------------
  assign step_req = (state == IDLE) &&
                    (single_step || (run && (step_cnt == CNT_LAST)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_cnt <= '0;
      step     <= 1'b0;
    end else begin
      step <= step_req;
      if (busy || !run || step_req) step_cnt <= '0;
      else                          step_cnt <= step_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_life_board_loader.sv
// -----------------------------------------------------------------------------
// tb_life_board_loader
//
// Directed bench for life_board_loader with STEP_PERIOD=4. A negedge monitor
// logs every tile write as {load_done, vali_selector, vali}, every step pulse
// with its cycle number, frame_err pulses and in_ready/WRITE consistency.
// Each directed scenario compares these logs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_life_board_loader;

  localparam int unsigned STEP_PERIOD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_sof = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        run = 1'b0;
  logic        single_step = 1'b0;
  logic [15:0] vali;
  logic [1:0]  vali_selector;
  logic        write_enb;
  logic        step;
  logic        busy;
  logic        load_done;
  logic        frame_err;

  life_board_loader #(
    .STEP_PERIOD(STEP_PERIOD),
    .CNT_W      (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_sof       (in_sof),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .run          (run),
    .single_step  (single_step),
    .vali         (vali),
    .vali_selector(vali_selector),
    .write_enb    (write_enb),
    .step         (step),
    .busy         (busy),
    .load_done    (load_done),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state: written only by the processes below.
  int          cyc = 0;
  logic [18:0] wr_q[$];
  int          step_q[$];
  int          err_n = 0;
  int          rdy_bad = 0;

  // Expected write list for the next check_writes call.
  logic [18:0] exp_q[$];

  logic [7:0] frame_a [8] = '{8'h01, 8'h80, 8'hFF, 8'h00,
                              8'h34, 8'h12, 8'hCD, 8'hAB};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (write_enb) wr_q.push_back({load_done, vali_selector, vali});
      if (step)      step_q.push_back(cyc);
      if (frame_err) err_n <= err_n + 1;
      // While loading, in_ready must be low exactly in the write cycle.
      if (busy && (in_ready == write_enb)) rdy_bad <= rdy_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte and hold it until it transfers. Called at posedge+1.
  task automatic send(input logic [7:0] d, input logic sof);
    int k = 0;
    in_data  = d;
    in_sof   = sof;
    in_valid = 1'b1;
    while (!in_ready && k < 20) begin
      tick(1);
      k++;
    end
    if (k == 20) check("ready_timeout", 32'd0, 32'd1);
    tick(1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic gap);
    for (int i = 0; i < 8; i++) begin
      send(frame_a[i], i == 0);
      if (gap) tick(1);
    end
  endtask

  task automatic check_writes(input string tag, input int base);
    check({tag, "_count"}, wr_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < wr_q.size()) check(tag, wr_q[base + i], exp_q[i]);
      else                        check(tag, 32'hFFFF_FFFF, exp_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int e0;
    int sb;
    int c0;
    int cw;

    // ---- reset state ----------------------------------------------------
    tick(2);
    check("reset_outs", {in_ready, vali, vali_selector, write_enb, step, busy,
                         load_done, frame_err}, 32'd0);
    reset = 1'b1;
    check("ready_pre", in_ready, 1'b0);
    tick(1);
    check("ready_post", in_ready, 1'b1);

    // ---- clean load -----------------------------------------------------
    base = wr_q.size();
    e0   = err_n;
    send_frame(1'b0);
    check("busy_last_write", busy, 1'b1);
    tick(1);
    check("busy_after_load", busy, 1'b0);
    tick(1);
    exp_q = '{19'h08001, 19'h100FF, 19'h21234, 19'h7ABCD};
    check_writes("clean", base);
    check("clean_err", err_n - e0, 32'd0);

    // ---- backpressure ---------------------------------------------------
    base = wr_q.size();
    e0   = err_n;
    send_frame(1'b1);
    tick(2);
    check_writes("bp", base);
    check("bp_err", err_n - e0, 32'd0);
    check("bp_ready", rdy_bad, 32'd0);

    // ---- protocol errors ------------------------------------------------
    base = wr_q.size();
    e0   = err_n;
    send(8'hAA, 1'b0);
    tick(2);
    check("idle_nosof_err", err_n - e0, 32'd1);
    check("idle_nosof_wr", wr_q.size() - base, 32'd0);

    base = wr_q.size();
    e0   = err_n;
    send(8'h01, 1'b1);
    send(8'h80, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    tick(2);
    check("restart_err", err_n - e0, 32'd1);
    exp_q = '{19'h08001, 19'h02211, 19'h14433, 19'h26655, 19'h78877};
    check_writes("restart", base);

    // ---- periodic step --------------------------------------------------
    sb  = step_q.size();
    c0  = cyc;
    run = 1'b1;
    tick(13);
    check("per_count", step_q.size() - sb, 32'd3);
    for (int i = 0; i < 3; i++)
      if (sb + i < step_q.size())
        check("per_cycle", step_q[sb + i] - c0, 4 * (i + 1));

    // Load starting two cycles into a period.
    tick(1);
    sb = step_q.size();
    base = wr_q.size();
    send_frame(1'b0);
    cw = cyc;
    tick(7);
    run = 1'b0;
    check("load_step_count", step_q.size() - sb, 32'd1);
    if (sb < step_q.size()) check("load_step_cycle", step_q[sb] - cw, 32'd5);
    exp_q = '{19'h08001, 19'h100FF, 19'h21234, 19'h7ABCD};
    check_writes("run_load", base);

    // ---- single_step ----------------------------------------------------
    tick(2);
    sb = step_q.size();
    single_step = 1'b1;
    tick(1);
    single_step = 1'b0;
    tick(3);
    check("ss_idle", step_q.size() - sb, 32'd1);

    sb  = step_q.size();
    c0  = cyc;
    run = 1'b1;
    tick(3);
    single_step = 1'b1;
    tick(1);
    single_step = 1'b0;
    tick(3);
    run = 1'b0;
    check("ss_coincide", step_q.size() - sb, 32'd1);
    if (sb < step_q.size()) check("ss_coincide_cyc", step_q[sb] - c0, 32'd4);

    tick(2);
    sb   = step_q.size();
    base = wr_q.size();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) single_step = 1'b1;
      send(frame_a[i], i == 0);
      single_step = 1'b0;
    end
    tick(4);
    check("ss_busy", step_q.size() - sb, 32'd0);
    check_writes("ss_load", base);

    // ---- async reset mid-load -------------------------------------------
    base = wr_q.size();
    for (int i = 0; i < 5; i++) send(frame_a[i], i == 0);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_outs", {in_ready, vali, vali_selector, write_enb, step,
                            busy, load_done, frame_err}, 32'd0);
    exp_q = '{19'h08001, 19'h100FF};
    check_writes("pre_reset", base);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1);
    base = wr_q.size();
    e0   = err_n;
    send(8'h55, 1'b0);
    tick(2);
    check("post_reset_err", err_n - e0, 32'd1);
    check("post_reset_nowr", wr_q.size() - base, 32'd0);
    base = wr_q.size();
    send_frame(1'b0);
    tick(2);
    exp_q = '{19'h08001, 19'h100FF, 19'h21234, 19'h7ABCD};
    check_writes("post_reset", base);
    check("ready_total", rdy_bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
